// File: rtl/mips32_pipe.sv
// Five-stage MIPS32-subset pipeline with unified word memory,
// interlocked hazards, EX-stage branches and halt handling.
module mips32_pipe #(
    parameter int MEM_DEPTH = 1024,
    parameter int WIDTH     = 32
) (
    input  logic clk1,
    input  logic rst,
    output logic halted
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] ir;
        logic [WIDTH-1:0] pc;
    } if_id_t;

    typedef struct packed {
        logic             v;
        logic [5:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] pc;
        logic [4:0]       dst;
        logic             wr;
    } id_ex_t;

    typedef struct packed {
        logic             v;
        logic [5:0]       op;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] b;
        logic [4:0]       dst;
        logic             wr;
    } ex_mem_t;

    typedef struct packed {
        logic             v;
        logic [5:0]       op;
        logic [WIDTH-1:0] res;
        logic [4:0]       dst;
        logic             wr;
    } mem_wb_t;

    logic [WIDTH-1:0] Mem [0:MEM_DEPTH-1];
    logic [WIDTH-1:0] Reg [0:31];
    logic [WIDTH-1:0] PC, pc_d;
    logic             HALTED, halted_d;
    logic             TAKEN_BRANCH;
    logic             stop_q, stop_d;

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [5:0]       id_op;
    logic [4:0]       id_rs, id_rt, id_rd, id_dst;
    logic [WIDTH-1:0] id_imm, id_a, id_b;
    logic             id_r, id_ialu, id_wr, use_rs, use_rt;
    logic             haz_rs, haz_rt, stall, wb_we;
    logic [WIDTH-1:0] ex_res, target, f_ir;
    logic             taken, mem_we;
    logic [AW-1:0]    mem_addr;

    assign halted = HALTED;
    assign wb_we  = mem_wb_q.v && mem_wb_q.wr && !HALTED;

    // Decode, register read with WB bypass, and the hazard interlock
    always_comb begin
        id_op   = if_id_q.ir[31:26];
        id_rs   = if_id_q.ir[25:21];
        id_rt   = if_id_q.ir[20:16];
        id_rd   = if_id_q.ir[15:11];
        id_imm  = {{(WIDTH-16){if_id_q.ir[15]}}, if_id_q.ir[15:0]};
        id_r    = id_op <= OP_MUL;
        id_ialu = id_op inside {OP_ADDI, OP_SUBI, OP_SLTI};
        use_rs  = id_r || id_ialu || id_op inside {OP_LW, OP_SW, OP_BNEQZ, OP_BEQZ};
        use_rt  = id_r || id_op == OP_SW;
        id_dst  = id_r ? id_rd : id_rt;
        id_wr   = (id_r || id_ialu || id_op == OP_LW) && id_dst != 5'd0;
        if (id_rs == 5'd0)                       id_a = '0;
        else if (wb_we && mem_wb_q.dst == id_rs) id_a = mem_wb_q.res;
        else                                     id_a = Reg[id_rs];
        if (id_rt == 5'd0)                       id_b = '0;
        else if (wb_we && mem_wb_q.dst == id_rt) id_b = mem_wb_q.res;
        else                                     id_b = Reg[id_rt];
        haz_rs = id_rs != 5'd0 &&
            ((id_ex_q.v && id_ex_q.wr && id_ex_q.dst == id_rs) ||
             (ex_mem_q.v && ex_mem_q.wr && ex_mem_q.dst == id_rs));
        haz_rt = id_rt != 5'd0 &&
            ((id_ex_q.v && id_ex_q.wr && id_ex_q.dst == id_rt) ||
             (ex_mem_q.v && ex_mem_q.wr && ex_mem_q.dst == id_rt));
        stall = if_id_q.v && ((use_rs && haz_rs) || (use_rt && haz_rt));
    end

    always_comb begin
        case (id_ex_q.op)
            OP_ADD:  ex_res = id_ex_q.a + id_ex_q.b;
            OP_SUB:  ex_res = id_ex_q.a - id_ex_q.b;
            OP_AND:  ex_res = id_ex_q.a & id_ex_q.b;
            OP_OR:   ex_res = id_ex_q.a | id_ex_q.b;
            OP_SLT:  ex_res = {{(WIDTH-1){1'b0}},
                               $signed(id_ex_q.a) < $signed(id_ex_q.b)};
            OP_MUL:  ex_res = id_ex_q.a * id_ex_q.b;
            OP_SUBI: ex_res = id_ex_q.a - id_ex_q.imm;
            OP_SLTI: ex_res = {{(WIDTH-1){1'b0}},
                               $signed(id_ex_q.a) < $signed(id_ex_q.imm)};
            OP_ADDI, OP_LW, OP_SW: ex_res = id_ex_q.a + id_ex_q.imm;
            default: ex_res = '0;
        endcase
        taken  = id_ex_q.v &&
            ((id_ex_q.op == OP_BNEQZ && id_ex_q.a != '0) ||
             (id_ex_q.op == OP_BEQZ && id_ex_q.a == '0));
        target = id_ex_q.pc + 1 + id_ex_q.imm;
    end

    always_comb begin
        mem_addr = ex_mem_q.res[AW-1:0];
        mem_we   = ex_mem_q.v && ex_mem_q.op == OP_SW && !HALTED;
        f_ir     = Mem[PC[AW-1:0]];

        ex_mem_d = '{v: id_ex_q.v, op: id_ex_q.op, res: ex_res,
                     b: id_ex_q.b, dst: id_ex_q.dst, wr: id_ex_q.wr};
        mem_wb_d = '{v: ex_mem_q.v, op: ex_mem_q.op,
                     res: ex_mem_q.op == OP_LW ? Mem[mem_addr] : ex_mem_q.res,
                     dst: ex_mem_q.dst, wr: ex_mem_q.wr};
        halted_d = HALTED || (mem_wb_q.v && mem_wb_q.op == OP_HLT);

        pc_d    = PC;
        stop_d  = stop_q;
        if_id_d = if_id_q;
        id_ex_d = '0;
        // A taken branch also cancels any HLT sitting in its shadow
        if (taken) begin
            pc_d    = target;
            stop_d  = 1'b0;
            if_id_d = '0;
        end else if (!stall) begin
            id_ex_d = '{v: if_id_q.v, op: id_op, a: id_a, b: id_b,
                        imm: id_imm, pc: if_id_q.pc, dst: id_dst,
                        wr: id_wr && if_id_q.v};
            if (!stop_q && !HALTED) begin
                if_id_d = '{v: 1'b1, ir: f_ir, pc: PC};
                pc_d    = PC + 1;
                stop_d  = f_ir[31:26] == OP_HLT;
            end else begin
                if_id_d = '0;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            PC           <= '0;
            HALTED       <= 1'b0;
            TAKEN_BRANCH <= 1'b0;
            stop_q       <= 1'b0;
            if_id_q      <= '0;
            id_ex_q      <= '0;
            ex_mem_q     <= '0;
            mem_wb_q     <= '0;
        end else begin
            PC           <= pc_d;
            HALTED       <= halted_d;
            TAKEN_BRANCH <= taken;
            stop_q       <= stop_d;
            if_id_q      <= if_id_d;
            id_ex_q      <= id_ex_d;
            ex_mem_q     <= ex_mem_d;
            mem_wb_q     <= mem_wb_d;
        end
    end

    // Memory and registers are not reset so preloads survive
    always_ff @(posedge clk1) begin
        if (!rst && mem_we) Mem[mem_addr] <= ex_mem_q.b;
    end

    always_ff @(posedge clk1) begin
        if (!rst && wb_we) Reg[mem_wb_q.dst] <= mem_wb_q.res;
    end

endmodule

// File: tb/tb_mips32_pipe.sv
// Directed-program bench for mips32_pipe: loads programs into memory,
// runs to halt and checks memory, registers and control state.
module tb_mips32_pipe;
    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    logic halted;

    int vec_cnt = 0;
    int err_cnt = 0;

    mips32_pipe #(.MEM_DEPTH(1024), .WIDTH(32)) dut (
        .clk1  (clk1),
        .rst   (rst),
        .halted(halted)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op,
                                          input int rs, input int rt,
                                          input int rd);
        return {op, rs[4:0], rt[4:0], rd[4:0], 11'b0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op,
                                          input int rs, input int rt,
                                          input int imm);
        return {op, rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    task automatic hold_reset();
        @(negedge clk1);
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        for (int i = 0; i < 1024; i++) dut.Mem[i] = 32'd0;
        for (int k = 0; k < 32; k++) dut.Reg[k] = k;
    endtask

    task automatic release_reset();
        @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic run(input string tag, input int max);
        int cyc;
        cyc = 0;
        while (!halted && cyc < max) begin
            @(negedge clk1);
            cyc++;
        end
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic load_fact();
        dut.Mem[0] = enc_i(6'b001010, 0, 10, 1);
        dut.Mem[1] = enc_i(6'b001010, 0, 3, 5);
        dut.Mem[2] = enc_r(6'b000101, 10, 3, 10);
        dut.Mem[3] = enc_i(6'b001011, 3, 3, 1);
        dut.Mem[4] = enc_i(6'b001101, 3, 0, -3);
        dut.Mem[5] = enc_i(6'b001001, 0, 10, 200);
        dut.Mem[6] = 32'hfc000000;
    endtask

    initial begin
        int  taken_cnt;
        int  cyc;
        logic bad;

        // Load/store program, then reset and rerun
        hold_reset();
        dut.Mem[0]   = 32'h28010078;
        dut.Mem[1]   = 32'h20220000;
        dut.Mem[2]   = 32'h2842002d;
        dut.Mem[3]   = 32'h24220001;
        dut.Mem[4]   = 32'hfc000000;
        dut.Mem[120] = 32'd85;
        release_reset();
        run("ls_halt", 30);
        chk("ls_mem121", dut.Mem[121], 32'd130);
        chk("ls_mem120", dut.Mem[120], 32'd85);
        chk("ls_r1", dut.Reg[1], 32'd120);

        dut.Mem[121] = 32'd0;
        @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_pc", dut.PC, 32'd0);
        chk("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);
        release_reset();
        run("rerun_halt", 30);
        chk("rerun_mem121", dut.Mem[121], 32'd130);

        // Back-to-back dependent ALU ops
        hold_reset();
        dut.Mem[0] = enc_i(6'b001010, 0, 1, 10);
        dut.Mem[1] = enc_i(6'b001010, 0, 2, 20);
        dut.Mem[2] = enc_r(6'b000000, 1, 2, 3);
        dut.Mem[3] = enc_r(6'b000001, 3, 1, 4);
        dut.Mem[4] = enc_r(6'b000101, 3, 4, 5);
        dut.Mem[5] = 32'hfc000000;
        release_reset();
        run("alu_halt", 60);
        chk("alu_r3", dut.Reg[3], 32'd30);
        chk("alu_r4", dut.Reg[4], 32'd20);
        chk("alu_r5", dut.Reg[5], 32'd600);

        // Factorial loop; Mem[200] may only ever be 0 or the final 120
        hold_reset();
        load_fact();
        release_reset();
        taken_cnt = 0;
        bad = 1'b0;
        cyc = 0;
        while (!halted && cyc < 300) begin
            @(negedge clk1);
            cyc++;
            if (dut.TAKEN_BRANCH) taken_cnt++;
            if (dut.Mem[200] != 32'd0 && dut.Mem[200] != 32'd120) bad = 1'b1;
        end
        chk("fact_halt", {31'd0, halted}, 32'd1);
        chk("fact_mem200", dut.Mem[200], 32'd120);
        chk("fact_r3", dut.Reg[3], 32'd0);
        chk("fact_shadow", {31'd0, bad}, 32'd0);
        chk("fact_taken_cnt", taken_cnt, 32'd4);

        // R0 write discard and signed compares
        hold_reset();
        dut.Reg[1] = 32'hffffffff;
        dut.Reg[6] = 32'd55;
        dut.Reg[7] = 32'd55;
        dut.Mem[0] = enc_i(6'b001010, 0, 0, 7);
        dut.Mem[1] = enc_r(6'b000100, 0, 1, 6);
        dut.Mem[2] = enc_i(6'b001100, 1, 7, 0);
        dut.Mem[3] = 32'hfc000000;
        release_reset();
        run("slt_halt", 40);
        chk("slt_r0", dut.Reg[0], 32'd0);
        chk("slt_r6", dut.Reg[6], 32'd0);
        chk("slt_r7", dut.Reg[7], 32'd1);

        // HLT followed by an instruction that must never execute
        hold_reset();
        dut.Mem[0] = 32'hfc000000;
        dut.Mem[1] = enc_i(6'b001010, 0, 8, 99);
        release_reset();
        run("hlt_halt", 20);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk1);
            if (!halted) bad = 1'b1;
        end
        chk("hlt_sticky", {31'd0, bad}, 32'd0);
        chk("hlt_r8", dut.Reg[8], 32'd8);

        // Reset mid-program: nothing may be written while reset is held
        hold_reset();
        load_fact();
        release_reset();
        repeat (9) @(negedge clk1);
        rst = 1'b1;
        @(posedge clk1);
        #1;
        dut.Reg[10]  = 32'd77;
        dut.Reg[3]   = 32'd66;
        dut.Mem[200] = 32'd55;
        repeat (5) @(negedge clk1);
        chk("mid_r10", dut.Reg[10], 32'd77);
        chk("mid_r3", dut.Reg[3], 32'd66);
        chk("mid_mem200", dut.Mem[200], 32'd55);
        chk("mid_pc", dut.PC, 32'd0);
        release_reset();
        run("mid_halt", 300);
        chk("mid_rerun_mem200", dut.Mem[200], 32'd120);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mips32_pipe.md
Name: mips32_pipe

Overview:
- Five-stage in-order MIPS32-subset processor (IF, ID, EX, MEM, WB) with an internal unified word-addressed instruction/data memory and a 32x32 register file.
- Self-contained top-level compute block: a bench loads the program and data into internal memory, releases reset, then observes memory, registers and `halted`.
- Programs need not insert NOPs; data hazards are handled by a hardware interlock.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the unified memory; address = low log2(MEM_DEPTH) bits.
- WIDTH, 32, data, register and instruction width.

Ports:
- clk1  input  1  single system clock; all state updates on its rising edge.
- rst   input  1  synchronous, active-high reset.
- halted  output  1  high once an HLT instruction has retired; stays high until reset.

Behaviour:
- Hierarchically accessible internal state, with these exact names:
  - Mem[0:MEM_DEPTH-1] (32-bit)
  - Reg[0:31] (32-bit)
  - PC
  - HALTED (drives `halted`)
  - TAKEN_BRANCH
- Reset, synchronous:
  - PC=0, HALTED=0, TAKEN_BRANCH=0.
  - All pipeline registers become bubbles (valid=0).
  - Mem and Reg are NOT cleared, so preloads survive reset.
  - Reset mid-execution abandons all in-flight instructions.
- Encoding: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0] sign-extended to 32 bits.
- R-type, write rd = rs op rt:
  - ADD 000000
  - SUB 000001
  - AND 000010
  - OR 000011
  - SLT 000100 (signed, result 1/0)
  - MUL 000101 (low 32 bits)
- I-type, write rt:
  - ADDI 001010
  - SUBI 001011
  - SLTI 001100 (signed)
  - LW 001000: rt = Mem[rs+imm]
- SW 001001: Mem[rs+imm] = rt; no register write.
- Branches, target = PC_of_branch + 1 + imm:
  - BNEQZ 001101: taken if rs != 0.
  - BEQZ 001110: taken if rs == 0.
- HLT 111111.
- Any other opcode is a NOP.
- Arithmetic wraps modulo 2^32. PC increments by 1 (word addressing).
- Reg[0] reads as 0; writes to it are discarded.
- Pipeline timing: one stage per clock; no stall gives 5-cycle latency from fetch to WB.
  - IF: read Mem[PC], PC <= PC+1.
  - ID: read registers; WB write in the same cycle is bypassed to the ID read.
  - EX: ALU operation, effective address, branch decision.
  - MEM: load/store.
  - WB: register write.
- Data hazard interlock:
  - ID stalls when any source register it uses (rs; rt for R-type and SW) is nonzero and equals the destination of a valid writing instruction in EX or MEM.
  - During a stall, PC and IF/ID hold and a bubble is inserted into EX.
  - A load followed by a dependent instruction therefore stalls 2 cycles; no forwarding network.
- Branch:
  - Decided in EX. If taken: PC <= target, TAKEN_BRANCH pulses 1 cycle, and instructions in IF/ID and ID/EX are squashed (2-cycle penalty).
  - Not-taken costs nothing.
- Halt:
  - HLT fetched stops further fetch (PC frozen) and younger instructions are squashed.
  - When HLT reaches WB, HALTED <= 1; older instructions complete normally.
  - An HLT in a squashed branch shadow has no effect.
- After HALTED=1: no Mem or Reg writes until reset.
- Simultaneous SW to the same address as a fetch: the store wins for later fetches; no self-modifying-code guarantee within 3 instructions.

Test Plan:
- Load/store program, starting from Reg[k]=k and Mem[120]=85:
  - Program: ADDI R1,R0,120; LW R2,0(R1); ADDI R2,R2,45; SW R2,1(R1); HLT (encodings 28010078, 20220000, 2842002d, 24220001, fc000000).
  - Required: Mem[121]=130, Mem[120]=85, Reg[1]=120, halted=1 within 30 cycles.
- Back-to-back dependent ALU ops with no NOPs:
  - Program: ADDI R1,R0,10; ADDI R2,R0,20; ADD R3,R1,R2; SUB R4,R3,R1; MUL R5,R3,R4; HLT.
  - Required: R3=30, R4=20, R5=600.
- Branch loop (factorial):
  - Program: R10=1, R3=5; loop MUL R10,R10,R3; SUBI R3,R3,1; BNEQZ R3,loop; SW R10 to Mem[200]; HLT.
  - Required: Mem[200]=120, R3=0; the instruction after the BNEQZ is never executed while the branch is taken.
- R0 and SLT:
  - Program: ADDI R0,R0,7; SLT R6,R0,R1 with R1=-1; SLTI R7,R1,0.
  - Required: R0=0, R6=0, R7=1.
- Halt and reset:
  - HLT followed by ADDI R8,R0,99 -> R8 unchanged, halted stays 1 for 20 cycles.
  - Assert rst for 1 cycle -> halted=0, PC=0, program reruns with the same results.
  - rst mid-program -> no partial write after the reset edge.
